// File: rtl/dice_bram_pkg.sv
// Shared types and constants for the DIC BRAM port arbiter.
package dice_bram_pkg;

    typedef enum logic [1:0] {
        WAIT_FULL = 2'd0,
        ARB       = 2'd1,
        DRAIN     = 2'd2
    } arb_state_t;

    localparam logic        REQ_GRAD      = 1'b0;
    localparam logic        REQ_GAMMA     = 1'b1;
    localparam logic [31:0] BRAM_FULL_VAL = 32'd1;
    localparam int          BYTE_SHIFT    = 2;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Read-tag delay line: follows each BRAM read so its data can be steered back
// to the requester that issued it.
module bram_rd_tag_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic push_valid,
    input  logic push_id,
    output logic pop_valid,
    output logic pop_id,
    output logic empty
);

    logic [RD_LAT-1:0] vld;
    logic [RD_LAT-1:0] id;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            id  <= '0;
        end else begin
            vld[0] <= push_valid;
            id[0]  <= push_id;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                id[i]  <= id[i-1];
            end
        end
    end

    assign pop_valid = vld[RD_LAT-1];
    assign pop_id    = id[RD_LAT-1];
    // A read on the BRAM port this cycle is already in flight even before it enters the line.
    assign empty     = ~push_valid & ~(|vld);

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one byte-addressed BRAM port between the gradient and gamma engines.
//   state     | meaning
//   WAIT_FULL | image load not complete, no traffic
//   ARB       | round-robin (or gamma-only) grants, one transfer per cycle
//   DRAIN     | load flag dropped, waiting for in-flight reads to return
module bram_port_arbiter
    import dice_bram_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [31:0]           bram_full,
    input  logic                  grad_done,
    input  logic                  g_req,
    input  logic                  g_we,
    input  logic [ADDR_W-1:0]     g_addr,
    input  logic [DATA_W-1:0]     g_wdata,
    output logic                  g_gnt,
    output logic                  g_rvalid,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_W-1:0]     c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  bram_en,
    output logic [DATA_W/8-1:0]   bram_we,
    output logic [31:0]           bram_addr,
    output logic [DATA_W-1:0]     bram_din,
    input  logic [DATA_W-1:0]     bram_dout,
    output logic                  busy
);

    localparam int ADDR_PAD = 32 - ADDR_W - BYTE_SHIFT;

    arb_state_t state, state_nxt;
    logic       rr_last;
    logic       issue_id;
    logic       full_ok;
    logic       g_elig;
    logic       c_elig;
    logic       gnt_any;
    logic       tag_empty;
    logic       pop_valid;
    logic       pop_id;
    logic       push_valid;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    assign full_ok = (bram_full == BRAM_FULL_VAL);
    assign g_elig  = g_req & ~grad_done;
    assign c_elig  = c_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_FULL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        g_gnt     = 1'b0;
        c_gnt     = 1'b0;
        case (state)
            WAIT_FULL: begin
                if (full_ok) state_nxt = ARB;
            end
            ARB: begin
                if (!full_ok) begin
                    state_nxt = DRAIN;
                end else if (g_elig && c_elig) begin
                    // Tie goes to whoever was not served last.
                    if (rr_last == REQ_GRAD) c_gnt = 1'b1;
                    else                     g_gnt = 1'b1;
                end else if (g_elig) begin
                    g_gnt = 1'b1;
                end else if (c_elig) begin
                    c_gnt = 1'b1;
                end
            end
            DRAIN: begin
                if (tag_empty) state_nxt = WAIT_FULL;
            end
            default: state_nxt = WAIT_FULL;
        endcase
    end

    assign gnt_any   = g_gnt | c_gnt;
    assign sel_addr  = c_gnt ? c_addr  : g_addr;
    assign sel_wdata = c_gnt ? c_wdata : g_wdata;
    assign sel_we    = c_gnt ? c_we    : g_we;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bram_en   <= 1'b0;
            bram_we   <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
            issue_id  <= REQ_GRAD;
            rr_last   <= REQ_GAMMA;
        end else begin
            bram_en <= gnt_any;
            bram_we <= (gnt_any && sel_we) ? '1 : '0;
            if (gnt_any) begin
                bram_addr <= {{ADDR_PAD{1'b0}}, sel_addr, {BYTE_SHIFT{1'b0}}};
                bram_din  <= sel_wdata;
                issue_id  <= c_gnt ? REQ_GAMMA : REQ_GRAD;
                rr_last   <= c_gnt ? REQ_GAMMA : REQ_GRAD;
            end
        end
    end

    assign push_valid = bram_en & ~(|bram_we);

    bram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_valid (push_valid),
        .push_id    (issue_id),
        .pop_valid  (pop_valid),
        .pop_id     (pop_id),
        .empty      (tag_empty)
    );

    assign g_rvalid = pop_valid & (pop_id == REQ_GRAD);
    assign c_rvalid = pop_valid & (pop_id == REQ_GAMMA);
    assign rdata    = bram_dout;
    assign busy     = gnt_any | ~tag_empty;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a read-return scoreboard and a
// behavioural BRAM whose data is a fixed function of the byte address.
module tb_bram_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [31:0]         bram_full;
    logic                grad_done;
    logic                g_req, g_we, c_req, c_we;
    logic [ADDR_W-1:0]   g_addr, c_addr;
    logic [DATA_W-1:0]   g_wdata, c_wdata;
    logic                g_gnt, c_gnt, g_rvalid, c_rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                bram_en;
    logic [DATA_W/8-1:0] bram_we;
    logic [31:0]         bram_addr;
    logic [DATA_W-1:0]   bram_din;
    logic [DATA_W-1:0]   bram_dout;
    logic                busy;

    always #5 clock = ~clock;

    bram_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bram_full (bram_full),
        .grad_done (grad_done),
        .g_req     (g_req),
        .g_we      (g_we),
        .g_addr    (g_addr),
        .g_wdata   (g_wdata),
        .g_gnt     (g_gnt),
        .g_rvalid  (g_rvalid),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .rdata     (rdata),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .busy      (busy)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hA5A5_0F0F;
    endfunction

    // BRAM model: address captured while bram_en is high, data out RD_LAT cycles later.
    logic [31:0] mpipe [RD_LAT];
    always @(posedge clock) begin
        mpipe[0] <= bram_en ? bram_addr : 32'h0;
        for (int i = 1; i < RD_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bram_dout = mem_val(mpipe[RD_LAT-1]);

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;
    logic exp_last;
    logic winner;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Record accepted reads, advance one clock, then check the read-return side.
    task automatic tick();
        exp_t e;
        #1;
        if (g_req && g_gnt && !g_we) begin
            e.id = 1'b0; e.data = mem_val({20'h0, g_addr, 2'b00}); e.due = cyc + 1 + RD_LAT;
            sb.push_back(e);
        end
        if (c_req && c_gnt && !c_we) begin
            e.id = 1'b1; e.data = mem_val({20'h0, c_addr, 2'b00}); e.due = cyc + 1 + RD_LAT;
            sb.push_back(e);
        end
        @(posedge clock);
        cyc++;
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rvalid_steer", 32'({g_rvalid, c_rvalid}), e.id ? 32'd1 : 32'd2);
            chk("rdata", rdata, e.data);
        end else begin
            chk("rvalid_idle", 32'({g_rvalid, c_rvalid}), 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},   32'(bram_en),   32'd0);
        chk({tag, "_we"},   32'(bram_we),   32'd0);
        chk({tag, "_addr"}, bram_addr,      32'd0);
        chk({tag, "_din"},  bram_din,       32'd0);
        chk({tag, "_gnt"},  32'({g_gnt, c_gnt}), 32'd0);
        chk({tag, "_rv"},   32'({g_rvalid, c_rvalid}), 32'd0);
        chk({tag, "_busy"}, 32'(busy),      32'd0);
    endtask

    initial begin
        reset_n = 1'b0; bram_full = 32'd0; grad_done = 1'b0;
        g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        exp_last = 1'b1;
        #3;
        chk_all_zero("reset");
        tick(); tick();
        reset_n = 1'b1;

        // 1: held off until load complete, then first read
        g_req = 1'b1; g_addr = 12'h041;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t1_gnt_hold", 32'(g_gnt), 32'd0);
            chk("t1_en_hold", 32'(bram_en), 32'd0);
            tick();
        end
        bram_full = 32'd1;
        #1 chk("t1_gnt_wait", 32'(g_gnt), 32'd0);
        tick();
        #1 chk("t1_gnt", 32'(g_gnt), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        exp_last = 1'b0;
        g_req = 1'b0;
        #1;
        chk("t1_en", 32'(bram_en), 32'd1);
        chk("t1_addr", bram_addr, 32'h104);
        chk("t1_we", 32'(bram_we), 32'd0);
        for (int i = 0; i < 4; i++) tick();

        // 2: both requesting continuously -> alternate
        g_addr = 12'h010; c_addr = 12'h020; g_req = 1'b1; c_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            winner = ~exp_last;
            #1;
            chk("t2_g_gnt", 32'(g_gnt), 32'(winner == 1'b0));
            chk("t2_c_gnt", 32'(c_gnt), 32'(winner == 1'b1));
            tick();
            exp_last = winner;
            #1 chk("t2_addr", bram_addr, winner ? 32'h80 : 32'h40);
        end
        g_req = 1'b0; c_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // 3: grad_done masks gradient; gamma write
        grad_done = 1'b1; g_req = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_wdata = 32'hDEADBEEF; c_addr = 12'h47E;
        #1;
        chk("t3_g_gnt", 32'(g_gnt), 32'd0);
        chk("t3_c_gnt", 32'(c_gnt), 32'd1);
        tick();
        exp_last = 1'b1;
        c_req = 1'b0;
        #1;
        chk("t3_we", 32'(bram_we), 32'hF);
        chk("t3_din", bram_din, 32'hDEADBEEF);
        chk("t3_addr", bram_addr, 32'h11F8);
        chk("t3_g_masked", 32'(g_gnt), 32'd0);
        tick();
        g_req = 1'b0; grad_done = 1'b0; c_we = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // 4: two reads, then load flag drops -> drain, then resume
        g_addr = 12'h100; c_addr = 12'h200; g_req = 1'b1; c_req = 1'b1;
        #1 chk("t4_g_first", 32'(g_gnt), 32'd1);
        tick();
        g_req = 1'b0;
        #1 chk("t4_c_second", 32'(c_gnt), 32'd1);
        tick();
        exp_last = 1'b1;
        bram_full = 32'd0; g_req = 1'b1; c_req = 1'b1;
        #1 chk("t4_no_gnt_fall", 32'({g_gnt, c_gnt}), 32'd0);
        tick();
        #1 chk("t4_busy_drain", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            #1 chk("t4_no_gnt_drain", 32'({g_gnt, c_gnt}), 32'd0);
            tick();
        end
        chk("t4_idle", 32'(busy), 32'd0);
        bram_full = 32'd1;
        #1 chk("t4_wait_full", 32'({g_gnt, c_gnt}), 32'd0);
        tick();
        #1 chk("t4_resume_g", 32'(g_gnt), 32'd1);
        chk("t4_resume_c", 32'(c_gnt), 32'd0);
        tick();
        exp_last = 1'b0;
        g_req = 1'b0; c_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // 5: reset right after a read grant
        c_req = 1'b1; c_addr = 12'h333;
        #1 chk("t5_c_gnt", 32'(c_gnt), 32'd1);
        tick();
        c_req = 1'b0;
        #1 reset_n = 1'b0;
        #1 chk_all_zero("t5_reset");
        sb.delete();
        exp_last = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        reset_n = 1'b1;
        g_addr = 12'h100; c_addr = 12'h200; g_req = 1'b1; c_req = 1'b1;
        #1 chk("t5_wait_full", 32'({g_gnt, c_gnt}), 32'd0);
        tick();
        #1 chk("t5_tie_g", 32'(g_gnt), 32'd1);
        chk("t5_tie_c", 32'(c_gnt), 32'd0);
        tick();
        g_req = 1'b0; c_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
